mem_access_stage: RTL and testbench
===================================

# mem_access_stage

Memory-access stage of the pipelined MIPS core, and the producer feeding the write-back stage's result select. It takes the M-stage ALU result and control, performs loads and stores over a ready/valid data-memory port, and extracts and extends sub-word load data. It registers the outcome into the M/W boundary as ALU result, read data, MemtoReg, RegWrite and destination register, and stalls the pipeline while a memory transaction is outstanding.

## Interface
- DATA_WIDTH, 32, datapath width; only 32 is supported (byte lanes are fixed at 4).
- ADDR_REG_W, 5, register-file index width.

- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst_n  in  1  synchronous, active-low reset.
- i_ALUOutM  in  DATA_WIDTH  ALU result; this is the effective address for memory operations.
- i_WriteDataM  in  DATA_WIDTH  store data.
- i_MemReadM / i_MemWriteM  in  1 each  load / store request.
- i_MemSizeM  in  2  access size: 0 = byte, 1 = half, 2 = word (3 is treated as word).
- i_MemSignedM  in  1  sign-extend sub-word loads.
- i_MemtoRegM, i_RegWriteM  in  1 each  write-back control.
- i_WriteRegM  in  ADDR_REG_W  destination register.
- o_mem_req  out  1  request valid.
- o_mem_we  out  1  write request.
- o_mem_addr  out  DATA_WIDTH  word-aligned address.
- o_mem_wdata  out  DATA_WIDTH  lane-replicated store data.
- o_mem_be  out  4  byte enables.
- i_mem_ready  in  1  request accepted.
- i_mem_rvalid, i_mem_rdata  in  1 / DATA_WIDTH  read response.
- o_ALUOutW, o_ReadDataW  out  DATA_WIDTH  outputs to the write-back stage.
- o_MemtoRegW, o_RegWriteW  out  1 each  outputs to the write-back stage.
- o_WriteRegW  out  ADDR_REG_W  output to the write-back stage.
- o_StallM  out  1  hold the M stage and all earlier stages.

## Operation
- FSM states: IDLE, REQ, WAIT.
- **IDLE, non-memory instruction:** the M inputs are registered into the W outputs at the next edge. o_StallM = 0.
- **IDLE, memory operation (MemRead or MemWrite):**
  - o_StallM = 1 combinationally.
  - Address, size, signedness, store data and control are latched.
  - Next state is REQ.
  - o_RegWriteW = 0 is registered at that edge, making W a bubble.
- **MemRead and MemWrite both set:** treated as a load.
- **REQ:**
  - o_mem_req = 1; addr, we, be and wdata are held stable until i_mem_ready.
  - Store: acceptance completes the instruction.
  - Load: acceptance moves to WAIT.
- **WAIT:** o_mem_req = 0. On i_mem_rvalid the lane is extracted, the W outputs are written, and the FSM returns to IDLE.
- **Completion cycle** (ready in REQ for a store, rvalid in WAIT for a load): o_StallM = 0, so upstream advances at the same edge the W registers capture. In every other REQ/WAIT cycle o_StallM = 1 and o_RegWriteW = 0.
- **Byte lanes (little-endian, k = addr[1:0]):**
  - Byte: be = 1 << k; wdata = byte replicated ×4; load data = rdata[8k+7:8k].
  - Half: be = 0011 or 1100 (by addr[1]); wdata = half replicated ×2.
  - Word: be = 1111.
  - Extension: zero-extend, or sign-extend when i_MemSignedM is set.
- o_mem_addr = {addr[31:2], 2'b00}.
- i_mem_rvalid outside WAIT and i_mem_ready outside REQ are ignored.
- **Reset mid-transaction:** FSM → IDLE, the outstanding request is abandoned, and a late rvalid is dropped.

## Timing
- **Reset values:** all W outputs 0, o_mem_req 0, o_mem_we 0, o_mem_be 0, o_mem_addr 0, o_mem_wdata 0. o_StallM follows the combinational rule above.
- **ALU instruction:** 1-cycle latency to W.
- **Load with zero-wait memory** (ready in the first REQ cycle, rvalid the next cycle): the instruction occupies 3 cycles in M (IDLE, REQ, WAIT); W is valid after the third edge.
- **Store with zero-wait memory:** 2 cycles.
- Each extra wait cycle on ready or rvalid adds exactly one stall cycle.

## Configuration
- **MEM_MISALIGN_TRAP_EN defined:**
  - A half access with addr[0] = 1, or a word access with addr[1:0] != 0, issues no request.
  - It completes in the IDLE cycle with o_RegWriteW = 0 and o_MisalignW = 1 for one cycle, with o_ALUOutW holding the faulting address.
  - Adds the output port o_MisalignW (1 bit, reset 0).
- **MEM_MISALIGN_TRAP_EN not defined:** the offending low address bits are ignored (forced aligned), and no extra port exists.

## Structure
- Shared package holds:
  - mem_size_t constants: SIZE_BYTE = 0, SIZE_HALF = 1, SIZE_WORD = 2.
  - FSM state encoding.
- Sub-module load_extract: combinational lane select plus zero/sign extension (inputs rdata, offset, size, signed).

## Test plan
- **ALU passthrough:** ALUOutM = 0x0000_1234, RegWrite = 1, WriteReg = 5.
  - Next cycle o_ALUOutW = 0x1234, o_RegWriteW = 1, o_WriteRegW = 5; o_StallM never asserted.
- **Signed byte load:** addr 0x103, rdata 0x80FF_FF7F.
  - o_ReadDataW = 0xFFFF_FF80; unsigned variant gives 0x0000_0080; o_mem_addr = 0x100.
- **Half store:** addr 0x102, WriteData 0xABCD.
  - be = 1100, wdata = 0xABCD_ABCD; with ready delayed 3 cycles, o_StallM is high for exactly 4 cycles.
- **Word load with rvalid delayed 2 cycles:** rdata 0xDEAD_BEEF.
  - o_RegWriteW = 0 throughout the stall, then 1 with 0xDEAD_BEEF for one cycle.
- **Reset asserted in WAIT:**
  - FSM → IDLE, all W outputs 0; an rvalid the next cycle produces no W write.
- **Misaligned word load at 0x101 with the macro defined:**
  - No o_mem_req, o_MisalignW = 1, o_RegWriteW = 0.
  - Without the macro: address 0x100 is issued.

Source files
------------

// File: rtl/mem_access_stage_pkg.sv
// Shared types for the memory-access stage: access-size codes and FSM states.
package mem_access_stage_pkg;

  typedef logic [1:0] mem_size_t;

  localparam mem_size_t SIZE_BYTE = 2'd0;
  localparam mem_size_t SIZE_HALF = 2'd1;
  localparam mem_size_t SIZE_WORD = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

endpackage

// File: rtl/mem_access_stage_load_extract.sv
// Load-data lane selection with zero/sign extension of byte and half accesses.
module load_extract
  import mem_access_stage_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] rdata_i,
  input  logic [1:0]            offset_i,
  input  mem_size_t             size_i,
  input  logic                  signed_i,
  output logic [DATA_WIDTH-1:0] data_o
);

  logic [DATA_WIDTH-1:0] lane;
  logic [7:0]            byte_sel;
  logic [15:0]           half_sel;

  always_comb begin
    lane     = rdata_i >> {offset_i, 3'b000};
    byte_sel = lane[7:0];
    half_sel = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    data_o   = rdata_i;
    case (size_i)
      SIZE_BYTE: data_o = {{(DATA_WIDTH-8){signed_i & byte_sel[7]}}, byte_sel};
      SIZE_HALF: data_o = {{(DATA_WIDTH-16){signed_i & half_sel[15]}}, half_sel};
      default:   data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MIPS M stage: ready/valid data-memory access and M/W pipeline registers.
// Define MEM_MISALIGN_TRAP_EN to trap misaligned half/word accesses (adds o_MisalignW).
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_REG_W = 5
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [DATA_WIDTH-1:0] i_ALUOutM,
  input  logic [DATA_WIDTH-1:0] i_WriteDataM,
  input  logic                  i_MemReadM,
  input  logic                  i_MemWriteM,
  input  logic [1:0]            i_MemSizeM,
  input  logic                  i_MemSignedM,
  input  logic                  i_MemtoRegM,
  input  logic                  i_RegWriteM,
  input  logic [ADDR_REG_W-1:0] i_WriteRegM,
  output logic                  o_mem_req,
  output logic                  o_mem_we,
  output logic [DATA_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  output logic [3:0]            o_mem_be,
  input  logic                  i_mem_ready,
  input  logic                  i_mem_rvalid,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata,
  output logic [DATA_WIDTH-1:0] o_ALUOutW,
  output logic [DATA_WIDTH-1:0] o_ReadDataW,
  output logic                  o_MemtoRegW,
  output logic                  o_RegWriteW,
  output logic [ADDR_REG_W-1:0] o_WriteRegW,
  output logic                  o_StallM
`ifdef MEM_MISALIGN_TRAP_EN
  ,
  output logic                  o_MisalignW
`endif
);

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] addr_q, wdata_q;
  mem_size_t             size_q;
  logic                  signed_q, we_q, m2r_q, rw_q;
  logic [ADDR_REG_W-1:0] wreg_q;

  logic                  mem_op, misalign_m, latch, complete;
  logic [3:0]            be;
  logic [DATA_WIDTH-1:0] load_data;

  assign mem_op = i_MemReadM | i_MemWriteM;

`ifdef MEM_MISALIGN_TRAP_EN
  // Size codes 2 and 3 are both word accesses, so size[1] identifies a word.
  assign misalign_m = ((i_MemSizeM == SIZE_HALF) & i_ALUOutM[0]) |
                      (i_MemSizeM[1] & (|i_ALUOutM[1:0]));
`else
  assign misalign_m = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    o_StallM = 1'b0;
    latch    = 1'b0;
    complete = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_op && !misalign_m) begin
          o_StallM = 1'b1;
          latch    = 1'b1;
          state_d  = REQ;
        end
      end
      REQ: begin
        if (i_mem_ready && we_q) begin
          complete = 1'b1;
          state_d  = IDLE;
        end else begin
          o_StallM = 1'b1;
          if (i_mem_ready) state_d = WAIT;
        end
      end
      WAIT: begin
        if (i_mem_rvalid) begin
          complete = 1'b1;
          state_d  = IDLE;
        end else begin
          o_StallM = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    case (size_q)
      SIZE_BYTE: be = 4'b0001 << addr_q[1:0];
      SIZE_HALF: be = addr_q[1] ? 4'b1100 : 4'b0011;
      default:   be = 4'b1111;
    endcase
    case (size_q)
      SIZE_BYTE: o_mem_wdata = {4{wdata_q[7:0]}};
      SIZE_HALF: o_mem_wdata = {2{wdata_q[15:0]}};
      default:   o_mem_wdata = wdata_q;
    endcase
  end

  assign o_mem_req  = (state_q == REQ);
  assign o_mem_we   = o_mem_req & we_q;
  assign o_mem_be   = o_mem_req ? be : '0;
  assign o_mem_addr = {addr_q[DATA_WIDTH-1:2], 2'b00};

  load_extract #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_load_extract (
    .rdata_i  (i_mem_rdata),
    .offset_i (addr_q[1:0]),
    .size_i   (size_q),
    .signed_i (signed_q),
    .data_o   (load_data)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      size_q      <= SIZE_BYTE;
      signed_q    <= 1'b0;
      we_q        <= 1'b0;
      m2r_q       <= 1'b0;
      rw_q        <= 1'b0;
      wreg_q      <= '0;
      o_ALUOutW   <= '0;
      o_ReadDataW <= '0;
      o_MemtoRegW <= 1'b0;
      o_RegWriteW <= 1'b0;
      o_WriteRegW <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
      o_MisalignW <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if (latch) begin
        addr_q   <= i_ALUOutM;
        wdata_q  <= i_WriteDataM;
        size_q   <= i_MemSizeM;
        signed_q <= i_MemSignedM;
        we_q     <= i_MemWriteM & ~i_MemReadM;
        m2r_q    <= i_MemtoRegM;
        rw_q     <= i_RegWriteM;
        wreg_q   <= i_WriteRegM;
      end
`ifdef MEM_MISALIGN_TRAP_EN
      o_MisalignW <= (state_q == IDLE) & mem_op & misalign_m;
`endif
      // A memory op in IDLE registers a bubble; its real result arrives on completion.
      if (state_q == IDLE) begin
        o_ALUOutW   <= i_ALUOutM;
        o_MemtoRegW <= i_MemtoRegM;
        o_RegWriteW <= i_RegWriteM & ~mem_op;
        o_WriteRegW <= i_WriteRegM;
      end else if (complete) begin
        o_ALUOutW   <= addr_q;
        o_MemtoRegW <= m2r_q;
        o_RegWriteW <= rw_q;
        o_WriteRegW <= wreg_q;
        if (!we_q) o_ReadDataW <= load_data;
      end else begin
        o_RegWriteW <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed cases plus randomized traffic.
module tb_mem_access_stage;

`ifdef MEM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic [31:0] i_ALUOutM, i_WriteDataM;
  logic        i_MemReadM, i_MemWriteM;
  logic [1:0]  i_MemSizeM;
  logic        i_MemSignedM, i_MemtoRegM, i_RegWriteM;
  logic [4:0]  i_WriteRegM;
  logic        o_mem_req, o_mem_we;
  logic [31:0] o_mem_addr, o_mem_wdata;
  logic [3:0]  o_mem_be;
  logic        i_mem_ready, i_mem_rvalid;
  logic [31:0] i_mem_rdata;
  logic [31:0] o_ALUOutW, o_ReadDataW;
  logic        o_MemtoRegW, o_RegWriteW;
  logic [4:0]  o_WriteRegW;
  logic        o_StallM;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        o_MisalignW;
`endif

  int unsigned tests = 0;
  int unsigned fails = 0;

  always #5 i_clk = ~i_clk;

  mem_access_stage #(
    .DATA_WIDTH(32),
    .ADDR_REG_W(5)
  ) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_ALUOutM    (i_ALUOutM),
    .i_WriteDataM (i_WriteDataM),
    .i_MemReadM   (i_MemReadM),
    .i_MemWriteM  (i_MemWriteM),
    .i_MemSizeM   (i_MemSizeM),
    .i_MemSignedM (i_MemSignedM),
    .i_MemtoRegM  (i_MemtoRegM),
    .i_RegWriteM  (i_RegWriteM),
    .i_WriteRegM  (i_WriteRegM),
    .o_mem_req    (o_mem_req),
    .o_mem_we     (o_mem_we),
    .o_mem_addr   (o_mem_addr),
    .o_mem_wdata  (o_mem_wdata),
    .o_mem_be     (o_mem_be),
    .i_mem_ready  (i_mem_ready),
    .i_mem_rvalid (i_mem_rvalid),
    .i_mem_rdata  (i_mem_rdata),
    .o_ALUOutW    (o_ALUOutW),
    .o_ReadDataW  (o_ReadDataW),
    .o_MemtoRegW  (o_MemtoRegW),
    .o_RegWriteW  (o_RegWriteW),
    .o_WriteRegW  (o_WriteRegW),
    .o_StallM     (o_StallM)
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    .o_MisalignW  (o_MisalignW)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference behaviour written directly from the lane/extension rules.
  function automatic logic [31:0] ref_load(input logic [31:0] addr, input logic [31:0] rd,
                                           input logic [1:0] size, input bit sgn);
    logic [31:0] v;
    int unsigned k = addr % 4;
    if (size == 2'd0) begin
      v = (rd >> (8 * k)) % 256;
      if (sgn && v >= 128) v = v + 32'hFFFF_FF00;
    end else if (size == 2'd1) begin
      v = (k >= 2) ? rd / 65536 : rd % 65536;
      if (sgn && v >= 32768) v = v + 32'hFFFF_0000;
    end else begin
      v = rd;
    end
    return v;
  endfunction

  function automatic logic [3:0] ref_be(input logic [31:0] addr, input logic [1:0] size);
    int unsigned k = addr % 4;
    if (size == 2'd0) return 4'(1 << k);
    if (size == 2'd1) return (k >= 2) ? 4'd12 : 4'd3;
    return 4'd15;
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [31:0] wd, input logic [1:0] size);
    if (size == 2'd0) return (wd % 256) * 32'h0101_0101;
    if (size == 2'd1) return (wd % 65536) * 32'h0001_0001;
    return wd;
  endfunction

  task automatic drive_bubble();
    i_ALUOutM = '0; i_WriteDataM = '0; i_MemReadM = 0; i_MemWriteM = 0;
    i_MemSizeM = 0; i_MemSignedM = 0; i_MemtoRegM = 0; i_RegWriteM = 0; i_WriteRegM = '0;
  endtask

  // Presents one M-stage instruction, plays the memory, checks handshake, stall count and W.
  task automatic run_op(input string tag, input logic [31:0] alu, input logic [31:0] wd,
                        input bit rd_en, input bit wr_en, input logic [1:0] size, input bit sgn,
                        input bit m2r, input bit rw, input logic [4:0] wreg,
                        input int unsigned rdy_dly, input int unsigned vld_dly,
                        input logic [31:0] rdata);
    bit mem = rd_en | wr_en;
    bit load = rd_en;
    bit mis = ((size == 2'd1) && (alu % 2 == 1)) || ((size >= 2'd2) && (alu % 4 != 0));
    bit trap = TRAP && mem && mis;
    int unsigned exp_stall = (!mem || trap) ? 0 : (load ? 2 + rdy_dly + vld_dly : 1 + rdy_dly);
    int unsigned cyc = 0, stalls = 0, rq = 0, vc = 0;
    bit accepted = 0, done = 0, saw_req = 0;

    @(negedge i_clk);
    i_ALUOutM = alu; i_WriteDataM = wd; i_MemReadM = rd_en; i_MemWriteM = wr_en;
    i_MemSizeM = size; i_MemSignedM = sgn; i_MemtoRegM = m2r; i_RegWriteM = rw;
    i_WriteRegM = wreg; i_mem_ready = 0; i_mem_rvalid = 0;
    while (!done && cyc < 64) begin
      if (cyc > 0) begin
        @(negedge i_clk);
        i_mem_ready = 0; i_mem_rvalid = 0;
        chk({tag, " rw_bubble"}, 32'(o_RegWriteW), 32'd0);
      end
      #1;
      if (o_mem_req) begin
        if (!saw_req) begin
          chk({tag, " addr"}, o_mem_addr, alu & 32'hFFFF_FFFC);
          chk({tag, " we"}, 32'(o_mem_we), 32'(!load));
          chk({tag, " be"}, 32'(o_mem_be), 32'(ref_be(alu, size)));
          if (!load) chk({tag, " wdata"}, o_mem_wdata, ref_wdata(wd, size));
        end
        saw_req = 1;
        i_mem_rvalid = 1'($urandom_range(0, 1));
        i_mem_rdata = $urandom;
        if (rq == rdy_dly) begin
          i_mem_ready = 1; accepted = 1;
        end else begin
          rq++;
        end
      end else if (accepted && load) begin
        if (vc == vld_dly) begin
          i_mem_rvalid = 1; i_mem_rdata = rdata;
        end else begin
          vc++; i_mem_rdata = $urandom;
        end
      end
      #1;
      if (o_StallM) stalls++; else done = 1;
      cyc++;
    end
    chk({tag, " finished"}, 32'(done), 32'd1);
    chk({tag, " stalls"}, stalls, exp_stall);
    chk({tag, " req_seen"}, 32'(saw_req), 32'(mem && !trap));
    @(negedge i_clk);
    i_mem_ready = 0; i_mem_rvalid = 0;
    chk({tag, " ALUOutW"}, o_ALUOutW, alu);
    chk({tag, " RegWriteW"}, 32'(o_RegWriteW), 32'(rw && !trap));
    chk({tag, " MemtoRegW"}, 32'(o_MemtoRegW), 32'(m2r));
    chk({tag, " WriteRegW"}, 32'(o_WriteRegW), 32'(wreg));
    if (load && !trap) chk({tag, " ReadDataW"}, o_ReadDataW, ref_load(alu, rdata, size, sgn));
`ifdef MEM_MISALIGN_TRAP_EN
    chk({tag, " MisalignW"}, 32'(o_MisalignW), 32'(trap));
`endif
    drive_bubble();
  endtask

  initial begin
    i_rst_n = 0; i_mem_ready = 0; i_mem_rvalid = 0; i_mem_rdata = '0;
    drive_bubble();
    repeat (2) @(negedge i_clk);
    chk("rst ALUOutW", o_ALUOutW, 32'd0);
    chk("rst ReadDataW", o_ReadDataW, 32'd0);
    chk("rst RegWriteW", 32'(o_RegWriteW), 32'd0);
    chk("rst MemtoRegW", 32'(o_MemtoRegW), 32'd0);
    chk("rst WriteRegW", 32'(o_WriteRegW), 32'd0);
    chk("rst req", 32'(o_mem_req), 32'd0);
    chk("rst we", 32'(o_mem_we), 32'd0);
    chk("rst be", 32'(o_mem_be), 32'd0);
    chk("rst addr", o_mem_addr, 32'd0);
    chk("rst wdata", o_mem_wdata, 32'd0);
    chk("rst stall", 32'(o_StallM), 32'd0);
    i_rst_n = 1;

    run_op("alu", 32'h0000_1234, 32'd0, 0, 0, 2'd2, 0, 0, 1, 5'd5, 0, 0, 32'd0);
    run_op("lb", 32'h0000_0103, 32'd0, 1, 0, 2'd0, 1, 1, 1, 5'd7, 0, 0, 32'h80FF_FF7F);
    chk("lb literal", o_ReadDataW, 32'hFFFF_FF80);
    run_op("lbu", 32'h0000_0103, 32'd0, 1, 0, 2'd0, 0, 1, 1, 5'd7, 1, 1, 32'h80FF_FF7F);
    chk("lbu literal", o_ReadDataW, 32'h0000_0080);
    run_op("sh", 32'h0000_0102, 32'h0000_ABCD, 0, 1, 2'd1, 0, 0, 0, 5'd0, 3, 0, 32'd0);
    run_op("lw", 32'h0000_0040, 32'd0, 1, 0, 2'd2, 0, 1, 1, 5'd9, 0, 2, 32'hDEAD_BEEF);
    chk("lw literal", o_ReadDataW, 32'hDEAD_BEEF);
    @(negedge i_clk);
    chk("lw one_cycle", 32'(o_RegWriteW), 32'd0);
    run_op("lw_mis", 32'h0000_0101, 32'd0, 1, 0, 2'd2, 0, 1, 1, 5'd3, 0, 0, 32'h1234_5678);
    run_op("ld_st_both", 32'h0000_0206, 32'h5555_AAAA, 1, 1, 2'd1, 1, 1, 1, 5'd4, 1, 0,
           32'h8001_7FFE);

    for (int i = 0; i < 60; i++) begin
      int unsigned sel = $urandom_range(0, 3);
      run_op($sformatf("rnd%0d", i), $urandom, $urandom, (sel == 1) || (sel == 3),
             (sel == 2) || (sel == 3), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
             $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
    end

    // Reset while a load waits for its response; a late rvalid must not reach W.
    @(negedge i_clk);
    i_ALUOutM = 32'h0000_0200; i_MemReadM = 1; i_MemSizeM = 2'd2; i_RegWriteM = 1;
    i_MemtoRegM = 1; i_WriteRegM = 5'd12;
    @(negedge i_clk);
    i_mem_ready = 1;
    @(negedge i_clk);
    i_mem_ready = 0;
    #1;
    chk("wait stall", 32'(o_StallM), 32'd1);
    chk("wait req", 32'(o_mem_req), 32'd0);
    i_rst_n = 0;
    drive_bubble();
    @(negedge i_clk);
    chk("mid rst ALUOutW", o_ALUOutW, 32'd0);
    chk("mid rst WriteRegW", 32'(o_WriteRegW), 32'd0);
    chk("mid rst MemtoRegW", 32'(o_MemtoRegW), 32'd0);
    chk("mid rst req", 32'(o_mem_req), 32'd0);
    chk("mid rst addr", o_mem_addr, 32'd0);
    i_rst_n = 1;
    i_mem_rvalid = 1; i_mem_rdata = 32'hCAFE_F00D;
    #1;
    chk("late rvalid stall", 32'(o_StallM), 32'd0);
    @(negedge i_clk);
    i_mem_rvalid = 0;
    chk("late rvalid RegWriteW", 32'(o_RegWriteW), 32'd0);
    chk("late rvalid ReadDataW", o_ReadDataW, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
